// File: rtl/botao_condicionador_if.sv
// Button conditioner bundle: raw button in, pulse/status out.
// The master side (stimulus or the board wrapper) drives btn_raw; the
// slave side (the conditioner) drives the request pulse and status.
interface botao_condicionador_if;
  logic       btn_raw;
  logic       bt;
  logic       pending;
  logic       locked;
  logic [7:0] press_count;

  modport master (
    output btn_raw,
    input  bt,
    input  pending,
    input  locked,
    input  press_count
  );

  modport slave (
    input  btn_raw,
    output bt,
    output pending,
    output locked,
    output press_count
  );
endinterface

// File: rtl/botao_condicionador.sv
// Pedestrian push-button conditioner placed directly upstream of the
// semaforo controller. The raw button is synchronised, then debounced.
// Each debounced press becomes a single-cycle bt request. After every
// pulse a lockout window blocks new pulses. A press that lands inside
// the window is remembered as one pending request and is issued as soon
// as the window closes. Further presses merge into that single request.
module botao_condicionador #(
  parameter logic [7:0] DEBOUNCE = 8'd4,
  parameter logic [7:0] LOCKOUT  = 8'd8
) (
  input  logic                  clk,
  input  logic                  rst,
  botao_condicionador_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  // Two-flop synchroniser for the asynchronous button.
  logic       s1_q;
  logic       s2_q;

  // Debounced level, its one-cycle-delayed copy, and the agreement counter.
  logic       db_q;
  logic       db_d;
  logic       db_dly_q;
  logic [7:0] db_cnt_q;
  logic [7:0] db_cnt_d;

  // Request FSM and its outputs.
  logic [0:0] state_q;
  logic [0:0] state_d;
  logic [7:0] lock_cnt_q;
  logic [7:0] lock_cnt_d;
  logic       bt_q;
  logic       bt_d;
  logic       pending_q;
  logic       pending_d;

  // Saturating press counter.
  logic [7:0] press_cnt_q;
  logic [7:0] press_cnt_d;

  logic       db_rise;

  // One-cycle event marking a debounced press (rising debounced level).
  assign db_rise = db_q & ~db_dly_q;

  // Synchroniser flops; reset clears them so nothing survives a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= bus.btn_raw;
      s2_q <= s1_q;
    end
  end

  // Debounce: count consecutive cycles of disagreement; any agreement restarts the count.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = 8'd0;
    if (s2_q != db_q) begin
      if (db_cnt_q == (DEBOUNCE - 8'd1)) begin
        db_d     = s2_q;
        db_cnt_d = 8'd0;
      end else begin
        db_cnt_d = db_cnt_q + 8'd1;
      end
    end
  end

  // Debounced level, its delayed copy for edge detection, and the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      db_cnt_q <= 8'd0;
    end else begin
      db_q     <= db_d;
      db_dly_q <= db_q;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Request FSM. The lockout counter is loaded with LOCKOUT on the pulse
  // edge and the window closes on the edge after it reaches zero, so the
  // controller stays locked for LOCKOUT+1 cycles and back-to-back pulses
  // are never closer than LOCKOUT+1 cycles apart. A press seen on the very
  // edge the window closes is served like a pending one.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    bt_d       = 1'b0;
    pending_d  = pending_q;
    if (state_q == ST_IDLE) begin
      pending_d = 1'b0;
      if (db_rise) begin
        bt_d       = 1'b1;
        lock_cnt_d = LOCKOUT;
        state_d    = ST_LOCK;
      end
    end else begin
      if (lock_cnt_q == 8'd0) begin
        if (pending_q || db_rise) begin
          bt_d       = 1'b1;
          pending_d  = 1'b0;
          lock_cnt_d = LOCKOUT;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        lock_cnt_d = lock_cnt_q - 8'd1;
        if (db_rise) begin
          pending_d = 1'b1;
        end
      end
    end
  end

  // FSM state, lockout counter and registered request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lock_cnt_q <= 8'd0;
      bt_q       <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      bt_q       <= bt_d;
      pending_q  <= pending_d;
    end
  end

  // Count every debounced press, merged or not, holding at 255.
  always_comb begin
    press_cnt_d = press_cnt_q;
    if (db_rise && (press_cnt_q != 8'hFF)) begin
      press_cnt_d = press_cnt_q + 8'd1;
    end
  end

  // Press counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_cnt_q <= 8'd0;
    end else begin
      press_cnt_q <= press_cnt_d;
    end
  end

  assign bus.bt          = bt_q;
  assign bus.pending     = pending_q;
  assign bus.locked      = (state_q == ST_LOCK);
  assign bus.press_count = press_cnt_q;

endmodule

// File: tb/tb_botao_condicionador.sv
// Directed bench for botao_condicionador. dutA uses DEBOUNCE=4, LOCKOUT=8;
// dutB uses DEBOUNCE=1 so several debounced presses fit in one window.
// Step k of a scenario is the k-th rising edge after its setup; outputs
// are sampled 1ns after that edge.
module tb_botao_condicionador;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  botao_condicionador_if busA ();
  botao_condicionador_if busB ();

  botao_condicionador #(.DEBOUNCE(8'd4), .LOCKOUT(8'd8)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  botao_condicionador #(.DEBOUNCE(8'd1), .LOCKOUT(8'd8)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  // Free-running 10ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive both buttons, then let one rising edge sample them.
  task automatic applyStimulus(input logic btnA, input logic btnB);
    busA.btn_raw = btnA;
    busB.btn_raw = btnB;
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles with both buttons low, then release.
  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Reset with the button already held: outputs clear, then normal latency.
  task automatic test_reset();
    logic expBt;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checks++;
    if (busA.bt !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_bt: got %b expected 0", busA.bt);
    end
    checks++;
    if (busA.pending !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_pending: got %b expected 0", busA.pending);
    end
    checks++;
    if (busA.locked !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_locked: got %b expected 0", busA.locked);
    end
    checks++;
    if (busA.press_count !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_count: got %0d expected 0", busA.press_count);
    end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1, 1'b0);
      expBt = (k == 7);
      checks++;
      if (busA.bt !== expBt) begin
        errors++; $display("[TB] FAIL reset_release_bt step %0d: got %b expected %b", k, busA.bt, expBt);
      end
    end
    for (int k = 1; k <= 20; k++) applyStimulus(1'b0, 1'b0);
    checks++;
    if (busA.locked !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_release_unlock: got %b expected 0", busA.locked);
    end
    checks++;
    if (busA.press_count !== 8'd1) begin
      errors++; $display("[TB] FAIL reset_release_count: got %0d expected 1", busA.press_count);
    end
  endtask

  // Clean press held 20 cycles: one pulse at step 7, locked steps 7..15.
  task automatic test_clean_press();
    logic expBt;
    logic expLocked;
    doReset();
    for (int k = 1; k <= 3; k++) applyStimulus(1'b0, 1'b0);
    for (int k = 1; k <= 22; k++) begin
      applyStimulus(k <= 20, 1'b0);
      expBt     = (k == 7);
      expLocked = (k >= 7) && (k <= 15);
      checks++;
      if (busA.bt !== expBt) begin
        errors++; $display("[TB] FAIL clean_bt step %0d: got %b expected %b", k, busA.bt, expBt);
      end
      checks++;
      if (busA.locked !== expLocked) begin
        errors++; $display("[TB] FAIL clean_locked step %0d: got %b expected %b", k, busA.locked, expLocked);
      end
    end
    checks++;
    if (busA.press_count !== 8'd1) begin
      errors++; $display("[TB] FAIL clean_count: got %0d expected 1", busA.press_count);
    end
    for (int k = 1; k <= 10; k++) applyStimulus(1'b0, 1'b0);
  endtask

  // Ten cycles of toggling, then stable high from step 11: pulse at step 17 only.
  task automatic test_bounce();
    logic expBt;
    logic b;
    doReset();
    for (int k = 1; k <= 25; k++) begin
      b = (k <= 10) ? logic'(k % 2 == 1) : 1'b1;
      applyStimulus(b, 1'b0);
      expBt = (k == 17);
      checks++;
      if (busA.bt !== expBt) begin
        errors++; $display("[TB] FAIL bounce_bt step %0d: got %b expected %b", k, busA.bt, expBt);
      end
    end
    checks++;
    if (busA.press_count !== 8'd1) begin
      errors++; $display("[TB] FAIL bounce_count: got %0d expected 1", busA.press_count);
    end
    for (int k = 1; k <= 20; k++) applyStimulus(1'b0, 1'b0);
  endtask

  // Second press during lockout: pending at step 15, second pulse at step 16.
  task automatic test_pending();
    logic expBt;
    logic expPending;
    logic expLocked;
    logic b;
    doReset();
    for (int k = 1; k <= 30; k++) begin
      b = (k <= 4) || (k >= 9);
      applyStimulus(b, 1'b0);
      expBt      = (k == 7) || (k == 16);
      expPending = (k == 15);
      expLocked  = (k >= 7) && (k <= 24);
      checks++;
      if (busA.bt !== expBt) begin
        errors++; $display("[TB] FAIL pending_bt step %0d: got %b expected %b", k, busA.bt, expBt);
      end
      checks++;
      if (busA.pending !== expPending) begin
        errors++; $display("[TB] FAIL pending_flag step %0d: got %b expected %b", k, busA.pending, expPending);
      end
      checks++;
      if (busA.locked !== expLocked) begin
        errors++; $display("[TB] FAIL pending_locked step %0d: got %b expected %b", k, busA.locked, expLocked);
      end
    end
    checks++;
    if (busA.press_count !== 8'd2) begin
      errors++; $display("[TB] FAIL pending_count: got %0d expected 2", busA.press_count);
    end
    for (int k = 1; k <= 20; k++) applyStimulus(1'b0, 1'b0);
  endtask

  // Reset while locked with a pending press, then a fresh press.
  task automatic test_reset_mid_lock();
    logic expBt;
    logic b;
    doReset();
    for (int k = 1; k <= 15; k++) begin
      b = (k <= 4) || (k >= 9);
      applyStimulus(b, 1'b0);
    end
    checks++;
    if (busA.pending !== 1'b1) begin
      errors++; $display("[TB] FAIL midlock_setup_pending: got %b expected 1", busA.pending);
    end
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0);
    rst = 1'b0;
    checks++;
    if (busA.pending !== 1'b0) begin
      errors++; $display("[TB] FAIL midlock_pending: got %b expected 0", busA.pending);
    end
    checks++;
    if (busA.locked !== 1'b0) begin
      errors++; $display("[TB] FAIL midlock_locked: got %b expected 0", busA.locked);
    end
    checks++;
    if (busA.bt !== 1'b0) begin
      errors++; $display("[TB] FAIL midlock_bt: got %b expected 0", busA.bt);
    end
    checks++;
    if (busA.press_count !== 8'd0) begin
      errors++; $display("[TB] FAIL midlock_count: got %0d expected 0", busA.press_count);
    end
    for (int k = 1; k <= 3; k++) applyStimulus(1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 1'b0);
      expBt = (k == 7);
      checks++;
      if (busA.bt !== expBt) begin
        errors++; $display("[TB] FAIL midlock_fresh_bt step %0d: got %b expected %b", k, busA.bt, expBt);
      end
    end
    for (int k = 1; k <= 20; k++) applyStimulus(1'b0, 1'b0);
  endtask

  // dutB: presses at steps 1,3,5,7 give rises at steps 4,6,8,10; one extra pulse at 13.
  task automatic test_multi_press();
    logic expBt;
    logic expPending;
    logic b;
    doReset();
    for (int k = 1; k <= 25; k++) begin
      b = (k <= 7) && (k % 2 == 1);
      applyStimulus(1'b0, b);
      expBt      = (k == 4) || (k == 13);
      expPending = (k >= 6) && (k <= 12);
      checks++;
      if (busB.bt !== expBt) begin
        errors++; $display("[TB] FAIL multi_bt step %0d: got %b expected %b", k, busB.bt, expBt);
      end
      checks++;
      if (busB.pending !== expPending) begin
        errors++; $display("[TB] FAIL multi_pending step %0d: got %b expected %b", k, busB.pending, expPending);
      end
    end
    checks++;
    if (busB.press_count !== 8'd4) begin
      errors++; $display("[TB] FAIL multi_count: got %0d expected 4", busB.press_count);
    end
  endtask

  // dutB: a press arriving on the window-closing edge is served immediately.
  task automatic test_back_to_back();
    logic expBt;
    logic expLocked;
    logic b;
    doReset();
    for (int k = 1; k <= 25; k++) begin
      b = (k == 1) || (k == 10);
      applyStimulus(1'b0, b);
      expBt     = (k == 4) || (k == 13);
      expLocked = (k >= 4) && (k <= 21);
      checks++;
      if (busB.bt !== expBt) begin
        errors++; $display("[TB] FAIL b2b_bt step %0d: got %b expected %b", k, busB.bt, expBt);
      end
      checks++;
      if (busB.pending !== 1'b0) begin
        errors++; $display("[TB] FAIL b2b_pending step %0d: got %b expected 0", k, busB.pending);
      end
      checks++;
      if (busB.locked !== expLocked) begin
        errors++; $display("[TB] FAIL b2b_locked step %0d: got %b expected %b", k, busB.locked, expLocked);
      end
    end
    checks++;
    if (busB.press_count !== 8'd2) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d expected 2", busB.press_count);
    end
  endtask

  // dutB: 300 presses; count reads 100 midway and holds at 255; bt never doubles.
  task automatic test_saturation();
    logic prevBt;
    doReset();
    prevBt = 1'b0;
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < 2; j++) begin
        applyStimulus(1'b0, (j == 0));
        checks++;
        if ((busB.bt & prevBt) !== 1'b0) begin
          errors++; $display("[TB] FAIL sat_double_bt press %0d: got %b expected 0", i, busB.bt & prevBt);
        end
        prevBt = busB.bt;
      end
      if (i == 99) begin
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0);
        prevBt = busB.bt;
        checks++;
        if (busB.press_count !== 8'd100) begin
          errors++; $display("[TB] FAIL sat_count_mid: got %0d expected 100", busB.press_count);
        end
      end
    end
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0);
    checks++;
    if (busB.press_count !== 8'd255) begin
      errors++; $display("[TB] FAIL sat_count_final: got %0d expected 255", busB.press_count);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    busA.btn_raw = 1'b0;
    busB.btn_raw = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_pending();
    test_reset_mid_lock();
    test_multi_press();
    test_back_to_back();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
